// File: rtl/dual_rgb_pattern_gen.sv
// Dual-link RGB888 test-pattern and video-timing generator.
// Ports: I_clk/I_rst/I_enable, I_mode/I_solid_rgb in; odd/even RGB, DE/HS/VS, frame pulse/count out.
module dual_rgb_pattern_gen #(
  parameter int H_ACTIVE = 960,
  parameter int H_FP     = 44,
  parameter int H_SYNC   = 22,
  parameter int H_BP     = 74,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_enable,
  input  logic [1:0]  I_mode,
  input  logic [23:0] I_solid_rgb,
  output logic [7:0]  O_R_data_o,
  output logic [7:0]  O_G_data_o,
  output logic [7:0]  O_B_data_o,
  output logic [7:0]  O_R_data_e,
  output logic [7:0]  O_G_data_e,
  output logic [7:0]  O_B_data_e,
  output logic        O_DE,
  output logic        O_HS,
  output logic        O_VS,
  output logic        O_frame_start,
  output logic [15:0] O_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Ramp needs h[6:0] and checker needs v[3], so keep a minimum width.
  localparam int HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 4) ? 4 : $clog2(V_TOTAL);
  localparam int BARW = H_ACTIVE / 8;
  localparam int CW = $clog2(BARW + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] B_LAST = CW'(BARW - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bar_q, bar_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;
  logic [23:0]   pix_o_q, pix_o_d;
  logic [23:0]   pix_e_q, pix_e_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          first;
  logic          h_last;
  logic          wrap;
  logic          de;
  logic [1:0]    cur_mode;
  logic [23:0]   cur_solid;
  logic [7:0]    ramp_o;
  logic [7:0]    ramp_e;

  function automatic logic [23:0] bar_rgb(input logic [2:0] b);
    unique case (b)
      3'd0: return 24'hFFFFFF;
      3'd1: return 24'hFFFF00;
      3'd2: return 24'h00FFFF;
      3'd3: return 24'h00FF00;
      3'd4: return 24'hFF00FF;
      3'd5: return 24'hFF0000;
      3'd6: return 24'h0000FF;
      3'd7: return 24'h000000;
    endcase
  endfunction

  always_comb begin
    first  = (h_q == '0) && (v_q == '0);
    h_last = (h_q == H_LAST);
    wrap   = h_last && (v_q == V_LAST);
    de     = (h_q < H_ACT) && (v_q < V_ACT);
    // First pixel of a frame uses the live inputs so the new mode shows at once.
    cur_mode  = first ? I_mode : mode_q;
    cur_solid = first ? I_solid_rgb : solid_q;
    ramp_o = {h_q[6:0], 1'b0};
    ramp_e = {h_q[6:0], 1'b1};

    h_d     = '0;
    v_d     = '0;
    bcnt_d  = '0;
    bar_d   = '0;
    mode_d  = mode_q;
    solid_d = solid_q;
    pix_o_d = '0;
    pix_e_d = '0;
    de_d    = 1'b0;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    fs_d    = 1'b0;
    fcnt_d  = fcnt_q;

    // Counts even when enable drops on the wrap cycle.
    if (wrap) fcnt_d = fcnt_q + 16'd1;

    if (I_enable) begin
      mode_d  = cur_mode;
      solid_d = cur_solid;
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) v_d = wrap ? '0 : v_q + 1'b1;
      else        v_d = v_q;

      // Bar index tracks h without a divide.
      if (!h_last) begin
        if (bcnt_q == B_LAST) begin
          bcnt_d = '0;
          bar_d  = bar_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
          bar_d  = bar_q;
        end
      end

      de_d = de;
      fs_d = first;
      if ((h_q >= HS_BEG) && (h_q < HS_END)) hs_d = HS_POL;
      if ((v_q >= VS_BEG) && (v_q < VS_END)) vs_d = VS_POL;

      if (de) begin
        case (cur_mode)
          2'd0: begin
            pix_o_d = {3{ramp_o}};
            pix_e_d = {3{ramp_e}};
          end
          2'd1: begin
            pix_o_d = bar_rgb(bar_q);
            pix_e_d = bar_rgb(bar_q);
          end
          2'd2: begin
            pix_o_d = {24{h_q[2] ^ v_q[3]}};
            pix_e_d = {24{h_q[2] ^ v_q[3]}};
          end
          default: begin
            pix_o_d = cur_solid;
            pix_e_d = cur_solid;
          end
        endcase
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      bcnt_q  <= '0;
      bar_q   <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      pix_o_q <= '0;
      pix_e_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      bcnt_q  <= bcnt_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      pix_o_q <= pix_o_d;
      pix_e_q <= pix_e_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign {O_R_data_o, O_G_data_o, O_B_data_o} = pix_o_q;
  assign {O_R_data_e, O_G_data_e, O_B_data_e} = pix_e_q;
  assign O_DE          = de_q;
  assign O_HS          = hs_q;
  assign O_VS          = vs_q;
  assign O_frame_start = fs_q;
  assign O_frame_cnt   = fcnt_q;

endmodule
